// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI command RAM: command opcodes and transmit-slot states.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        LOAD_WADDR = 2'b00,
        WRITE      = 2'b01,
        LOAD_RADDR = 2'b10,
        READ       = 2'b11
    } opcode_e;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_FULL  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous word array with a registered, enable-gated read port.
// The read register only changes on re, so it doubles as the held transmit word.
module spi_ram_mem #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 8,
    parameter int MEM_DEPTH    = 256,
    parameter int CLEAR_ON_RST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            if (CLEAR_ON_RST != 0) begin
                for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
            end
        end else begin
            rdata_q <= rdata_d;
            if (we) mem_q[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM for the SPI slave: write/read pointers, one-entry
// transmit slot with valid/ready back-pressure, and a sticky error flag.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 8,
    parameter int MEM_DEPTH    = 256,
    parameter int AUTO_INC     = 1,
    parameter int CLEAR_ON_RST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [DATA_SIZE+1:0] din,
    input  logic                 tx_ready,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 err
);

    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE still compares correctly.
    localparam logic [ADDR_SIZE:0]   DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);

    tx_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
    logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
    logic                 err_q, err_d;

    opcode_e              op;
    logic [DATA_SIZE-1:0] payload;
    logic [ADDR_SIZE-1:0] ld_addr;
    logic                 ld_ok;
    logic                 rd_ok;
    logic                 mem_we, mem_re;
    logic [ADDR_SIZE-1:0] mem_addr;

    function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] p);
        if (AUTO_INC == 0) return p;
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        op       = opcode_e'(din[DATA_SIZE+1:DATA_SIZE]);
        payload  = din[DATA_SIZE-1:0];
        ld_addr  = payload[ADDR_SIZE-1:0];
        ld_ok    = {1'b0, ld_addr} < DEPTH_W;
        // A full slot can take a new read only if the old word leaves this cycle.
        rd_ok    = rx_valid && (op == READ) && (state_q == TX_EMPTY || tx_ready);

        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        err_d    = err_q;
        state_d  = state_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = raddr_q;

        if (rx_valid) begin
            unique case (op)
                LOAD_WADDR: begin
                    if (ld_ok) waddr_d = ld_addr;
                    else       err_d   = 1'b1;
                end
                WRITE: begin
                    mem_we   = 1'b1;
                    mem_addr = waddr_q;
                    waddr_d  = bump(waddr_q);
                end
                LOAD_RADDR: begin
                    if (ld_ok) raddr_d = ld_addr;
                    else       err_d   = 1'b1;
                end
                READ: begin
                    if (rd_ok) begin
                        mem_re  = 1'b1;
                        raddr_d = bump(raddr_q);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        unique case (state_q)
            TX_EMPTY: if (rd_ok) state_d = TX_FULL;
            TX_FULL:  if (tx_ready && !rd_ok) state_d = TX_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_EMPTY;
            waddr_q <= '0;
            raddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
        end
    end

    spi_ram_mem #(
        .DATA_SIZE   (DATA_SIZE),
        .ADDR_SIZE   (ADDR_SIZE),
        .MEM_DEPTH   (MEM_DEPTH),
        .CLEAR_ON_RST(CLEAR_ON_RST)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(payload),
        .rdata(dout)
    );

    assign tx_valid = (state_q == TX_FULL);
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with MEM_DEPTH=200 covers range errors.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst, rx_valid, tx_ready;
    logic [9:0] din;
    logic [7:0] dout;
    logic       tx_valid, err;

    logic       rst_b, rx_valid_b, tx_ready_b;
    logic [9:0] din_b;
    logic [7:0] dout_b;
    logic       tx_valid_b, err_b;

    always #5 clk = ~clk;

    spi_ram_ctrl dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .din(din),
        .tx_ready(tx_ready), .dout(dout), .tx_valid(tx_valid), .err(err)
    );

    spi_ram_ctrl #(.MEM_DEPTH(200)) dut_b (
        .clk(clk), .rst(rst_b), .rx_valid(rx_valid_b), .din(din_b),
        .tx_ready(tx_ready_b), .dout(dout_b), .tx_valid(tx_valid_b), .err(err_b)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the default instance.
    int m_mem [256];
    int m_wp, m_rp, m_dout;
    bit m_full, m_err;
    localparam int DEPTH = 256;

    task automatic model(input bit r, input bit v, input int op, input int pay, input bit tr);
        bit took;
        if (r) begin
            m_dout = 0; m_full = 0; m_err = 0; m_wp = 0; m_rp = 0;
            return;
        end
        took = 0;
        if (v) begin
            case (op)
                0: if (pay < DEPTH) m_wp = pay; else m_err = 1;
                1: begin m_mem[m_wp] = pay; m_wp = (m_wp + 1) % DEPTH; end
                2: if (pay < DEPTH) m_rp = pay; else m_err = 1;
                default: begin
                    if (!m_full || tr) begin
                        took = 1;
                        m_dout = m_mem[m_rp];
                        m_rp = (m_rp + 1) % DEPTH;
                    end else m_err = 1;
                end
            endcase
        end
        if (took) m_full = 1;
        else if (tr) m_full = 0;
    endtask

    task automatic cyc(input bit r, input bit v, input int op, input int pay, input bit tr);
        rst = r; rx_valid = v; din = {op[1:0], pay[7:0]}; tx_ready = tr;
        @(posedge clk);
        model(r, v, op, pay, tr);
        #1;
    endtask

    task automatic cyc_b(input bit r, input bit v, input int op, input int pay, input bit tr);
        rst_b = r; rx_valid_b = v; din_b = {op[1:0], pay[7:0]}; tx_ready_b = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 1, 3, 0, 1);
        cyc(1, 0, 0, 0, 0);
        checks++; if (dout !== 8'h00)   begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        // Populate every word so later reads have defined contents.
        for (int i = 0; i < 256; i++) cyc(0, 1, 1, (i * 37 + 11) & 255, 0);
    endtask

    task automatic test_basic;
        cyc(0, 1, 0, 8'h10, 0);
        cyc(0, 1, 1, 8'hA5, 0);
        cyc(0, 1, 2, 8'h10, 0);
        cyc(0, 1, 3, 0, 1);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL basic_tx_valid: got %b expected 1", tx_valid); end
        checks++; if (dout !== 8'hA5)    begin errors++; $display("FAIL basic_dout: got %h expected a5", dout); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", tx_valid); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL basic_err: got %b expected 0", err); end
    endtask

    task automatic test_auto_inc;
        int exp [3] = '{8'h11, 8'h22, 8'h33};
        cyc(0, 1, 0, 8'hFE, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, exp[i], 0);
        cyc(0, 1, 2, 8'hFE, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3, 0, 1);
            checks++;
            if (dout !== 8'(exp[i]) || tx_valid !== 1'b1) begin
                errors++; $display("FAIL auto_inc_read%0d: got %h/%b expected %h/1", i, dout, tx_valid, exp[i]);
            end
        end
        cyc(0, 0, 0, 0, 1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL auto_inc_err: got %b expected 0", err); end
    endtask

    task automatic test_back_pressure;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 8'h40, 0);
        cyc(0, 1, 1, 8'h5A, 0);
        cyc(0, 1, 1, 8'h6B, 0);
        cyc(0, 1, 2, 8'h40, 0);
        cyc(0, 1, 3, 0, 0);
        checks++; if (dout !== 8'h5A || err !== 1'b0) begin errors++; $display("FAIL bp_first: got %h err %b expected 5a err 0", dout, err); end
        cyc(0, 1, 3, 0, 0);
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL bp_hold: got %h expected 5a", dout); end
        checks++; if (err !== 1'b1)   begin errors++; $display("FAIL bp_err: got %b expected 1", err); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL bp_full: got %b expected 1", tx_valid); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", tx_valid); end
        cyc(0, 1, 3, 0, 1);
        checks++; if (dout !== 8'h6B) begin errors++; $display("FAIL bp_raddr_once: got %h expected 6b", dout); end
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_same_cycle;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 8'h20, 0);
        cyc(0, 1, 1, 8'h01, 0);
        cyc(0, 1, 1, 8'h02, 0);
        cyc(0, 1, 2, 8'h20, 0);
        cyc(0, 1, 3, 0, 0);
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL same_first: got %h expected 01", dout); end
        cyc(0, 1, 3, 0, 1);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h02 || err !== 1'b0) begin
            errors++; $display("FAIL same_cycle: got v=%b d=%h e=%b expected v=1 d=02 e=0", tx_valid, dout, err);
        end
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid;
        cyc(0, 1, 0, 8'h30, 0);
        cyc(0, 1, 1, 8'hC3, 0);
        cyc(0, 1, 2, 8'h30, 0);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 3, 0, 0);
        cyc(1, 1, 3, 0, 1);
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got v=%b d=%h e=%b expected v=0 d=00 e=0", tx_valid, dout, err);
        end
        cyc(0, 1, 2, 8'h30, 0);
        cyc(0, 1, 3, 0, 1);
        checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL reset_retain: got %h expected c3", dout); end
        cyc(0, 1, 1, 8'h44, 1);
        cyc(0, 1, 2, 8'h00, 1);
        cyc(0, 1, 3, 0, 1);
        checks++; if (dout !== 8'h44) begin errors++; $display("FAIL reset_waddr0: got %h expected 44", dout); end
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 64) == 0, ($urandom % 4) != 0, int'($urandom % 4),
                int'($urandom % 256), ($urandom % 3) != 0);
            checks++;
            if (dout !== 8'(m_dout) || tx_valid !== m_full || err !== m_err) begin
                errors++;
                $display("FAIL random_%0d: got d=%h v=%b e=%b expected d=%h v=%b e=%b",
                         i, dout, tx_valid, err, 8'(m_dout), m_full, m_err);
            end
        end
    endtask

    task automatic test_range;
        cyc_b(1, 0, 0, 0, 0);
        cyc_b(0, 1, 0, 8'h05, 0);
        cyc_b(0, 1, 1, 8'h77, 0);
        checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL range_ok_err: got %b expected 0", err_b); end
        cyc_b(0, 1, 0, 8'hC8, 0);
        checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", err_b); end
        cyc_b(0, 1, 1, 8'h88, 0);
        cyc_b(0, 1, 2, 8'h06, 0);
        cyc_b(0, 1, 3, 0, 1);
        checks++; if (dout_b !== 8'h88) begin errors++; $display("FAIL range_waddr_kept: got %h expected 88", dout_b); end
        cyc_b(0, 1, 0, 8'hC7, 1);
        cyc_b(0, 1, 1, 8'h99, 1);
        cyc_b(0, 1, 1, 8'h9A, 1);
        cyc_b(0, 1, 2, 8'hC7, 1);
        cyc_b(0, 1, 3, 0, 1);
        checks++; if (dout_b !== 8'h99) begin errors++; $display("FAIL range_last: got %h expected 99", dout_b); end
        cyc_b(0, 1, 3, 0, 1);
        checks++; if (dout_b !== 8'h9A) begin errors++; $display("FAIL range_wrap: got %h expected 9a", dout_b); end
    endtask

    initial begin
        rst = 1; rx_valid = 0; din = '0; tx_ready = 0;
        rst_b = 1; rx_valid_b = 0; din_b = '0; tx_ready_b = 0;
        test_reset;
        test_basic;
        test_auto_inc;
        test_back_pressure;
        test_same_cycle;
        test_reset_mid;
        test_random;
        test_range;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised command-decoding RAM behind the SPI slave frame interface. It accepts 2-bit-opcode command words from the SPI receive path, maintains separate write and read address pointers with optional auto-increment and wrap, and returns read data through a valid/ready handshake with back-pressure and a sticky error flag. It replaces the fixed 8-bit, fire-and-forget RAM in the SPI slave datapath.

## Interface
- DATA_SIZE, 8, memory word width and command payload width
- ADDR_SIZE, 8, address pointer width; must be ≤ DATA_SIZE
- MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_SIZE
- AUTO_INC, 1, 1 = pointers post-increment after each data write / read; 0 = pointers static
- CLEAR_ON_RST, 0, 1 = reset also zeroes every memory word
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  command word on din valid this cycle; always accepted
- din  input  DATA_SIZE+2  [DATA_SIZE+1:DATA_SIZE] opcode, [DATA_SIZE-1:0] payload
- tx_ready  input  1  downstream (SPI transmit path) accepts dout this cycle
- dout  output  DATA_SIZE  read data; stable while tx_valid is high
- tx_valid  output  1  dout holds an unconsumed read result
- err  output  1  sticky error flag

## Operation
- Opcodes (rx_valid=1): 00 LOAD_WADDR, 01 WRITE, 10 LOAD_RADDR, 11 READ.
- LOAD_WADDR / LOAD_RADDR: pointer <= payload[ADDR_SIZE-1:0]. If that value ≥ MEM_DEPTH: pointer unchanged, err set.
- WRITE: mem[waddr] <= payload. If AUTO_INC: waddr <= (waddr == MEM_DEPTH-1) ? 0 : waddr+1.
- READ: accepted only if tx slot is free (see FSM) → dout <= mem[raddr], raddr incremented with the same wrap rule if AUTO_INC. Rejected READ: no memory access, raddr unchanged, dout unchanged, err set.
- Tx FSM: EMPTY (tx_valid=0) and FULL (tx_valid=1).
  - EMPTY + accepted READ → FULL.
  - FULL + tx_ready, no READ → EMPTY.
  - FULL + tx_ready + READ in same cycle → READ accepted, stays FULL, dout = new word.
  - FULL + no tx_ready + READ → READ rejected, err set, stays FULL.
- tx_ready while EMPTY is ignored.
- err clears only on rst.
- rx_valid=0: no state change except the tx handshake.

## Timing
- Reset (rst high at a clk edge): dout=0, tx_valid=0, err=0, waddr=0, raddr=0, FSM=EMPTY. Memory is cleared only if CLEAR_ON_RST=1, otherwise retained. Reset overrides every command and handshake in the same cycle. A pending tx result is discarded.
- WRITE at edge N: the word is readable by a READ presented at edge N+1 or later.
- READ accepted at edge N: dout/tx_valid valid after edge N (one-cycle latency), held until an edge with tx_ready=1.
- LOAD_RADDR at edge N followed by READ at N+1 reads the new address.
- Throughput: one command per cycle, with back-to-back reads sustained when tx_ready=1 every cycle.
- Pointer wrap MEM_DEPTH-1 → 0 occurs with no error.

## Structure
- Package spi_ram_pkg: opcode enum typedef (LOAD_WADDR, WRITE, LOAD_RADDR, READ) and the tx FSM state enum typedef (TX_EMPTY, TX_FULL).
- Sub-module spi_ram_mem: a single-port synchronous array with parameters DATA_SIZE/ADDR_SIZE/MEM_DEPTH/CLEAR_ON_RST, write enable, registered read with a read-enable input, and a clear-on-reset option. The top level holds the decoder, pointers, tx FSM and err.

## Test plan
- Defaults: reset, then LOAD_WADDR 0x10, WRITE 0xA5, LOAD_RADDR 0x10, READ with tx_ready=1 → tx_valid high one cycle after READ, dout=0xA5, then tx_valid low; err=0.
- AUTO_INC: LOAD_WADDR 0xFE, WRITE 0x11, 0x22, 0x33 → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33. LOAD_RADDR 0xFE and 3 READs → 0x11, 0x22, 0x33 in order.
- Back-pressure: tx_ready=0, READ (mem=0x5A), second READ → dout stays 0x5A, err=1, raddr advanced once only. Then tx_ready=1 → tx_valid drops next cycle.
- Same-cycle handshake: FULL with 0x01 and tx_ready=1 while READ of a word holding 0x02 → tx_valid stays 1, dout=0x02, err=0.
- Range error, with MEM_DEPTH=200: LOAD_WADDR 0xC8 → err=1, waddr unchanged; a subsequent WRITE goes to the previous address.
- Reset mid-operation: assert rst while FULL → tx_valid=0, dout=0, err=0 next cycle. With CLEAR_ON_RST=0, earlier data is still readable at its address.
